cbd2_sampler_ctrl: RTL and testbench

// - Sequences the CBD2 (eta=2) calculation unit to turn the PRF byte stream into one 256-coefficient noise polynomial.
// - Accepts 32-bit PRF words (32 words per polynomial) and drives each word through the cbd2 unit.
// - The cbd2 unit returns 8 packed 4-bit signed coefficients; this block unpacks and normalises them.
// - Emits one 12-bit coefficient per handshake, with its index, toward the NTT/poly buffer.

---
 rtl/cbd2_sampler_ctrl.sv | 158 +++++++++++++++
 tb/tb_cbd2_sampler_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbd2_sampler_ctrl.sv
// -----------------------------------------------------------------------------
// cbd2_sampler_ctrl
//
// Sequences an external CBD2 (eta=2) calculation unit to turn a stream of
// 32-bit PRF words into one polynomial of NCOEF noise coefficients.
//
// Each PRF word is handed to the cbd2 unit. One cycle later the unit returns
// 8 packed 4-bit two's-complement coefficients. This block buffers them and
// emits them one per handshake, lowest nibble first, with a running index.
//
// Per word:   LOAD (input handshake) -> WAIT (capture cal_dout) -> EMIT x8
// Per poly:   IDLE -start-> ... NCOEF/8 words ... -> DONE (one cycle) -> IDLE
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 one-cycle pulse, honoured only in IDLE
//   busy                  high in every state except IDLE
//   done                  one-cycle pulse after the last coefficient handshake
//   in_data/valid/ready   PRF word stream; in_ready is high only in LOAD
//   cal_set, cal_din      cbd2 unit enable and operand (combinational)
//   cal_dout              cbd2 unit result, valid the cycle after cal_set
//   out_data/idx/valid/ready  coefficient stream toward the NTT/poly buffer
//
// Configuration
//   CBD2_CTRL_MODQ_EN  defined:   negative coefficients map to Q+value,
//                                 giving out_data in [0, Q-1]
//                      undefined: coefficients are sign-extended to COEF_W
// -----------------------------------------------------------------------------
module cbd2_sampler_ctrl #(
  parameter int NCOEF  = 256,   // coefficients per polynomial, multiple of 8
  parameter int Q      = 3329,  // modulus for the mod-q output mapping
  parameter int COEF_W = 12     // output coefficient width
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cal_set,
  output logic [31:0]       cal_din,
  input  logic [31:0]       cal_dout,
  output logic [COEF_W-1:0] out_data,
  output logic [7:0]        out_idx,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] nib_buf;    // 8 packed coefficients of the current word
  logic [2:0]  nib_cnt;    // which nibble of nib_buf is on out_data
  logic [7:0]  coef_cnt;   // index of the coefficient on out_data

  logic              in_hs;
  logic              out_hs;
  logic              last_nib;
  logic              last_coef;
  logic [3:0]        nibble;
  logic [COEF_W-1:0] nib_sext;
  logic [COEF_W-1:0] coef_val;

  // ---------------------------------------------------------------------------
  // Handshakes and status
  // ---------------------------------------------------------------------------
  assign in_ready  = (state == S_LOAD);
  assign out_valid = (state == S_EMIT);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;

  // The cbd2 unit is driven straight from the input handshake so it computes
  // during the LOAD->WAIT edge and its result is ready to capture in WAIT.
  assign cal_set   = in_hs;
  assign cal_din   = in_data;

  assign last_nib  = (nib_cnt == 3'd7);
  assign last_coef = (coef_cnt == 8'(NCOEF - 1));

  // ---------------------------------------------------------------------------
  // Coefficient unpacking and normalisation
  // ---------------------------------------------------------------------------
  assign nibble   = nib_buf[{nib_cnt, 2'b00} +: 4];
  assign nib_sext = {{(COEF_W-4){nibble[3]}}, nibble};

`ifdef CBD2_CTRL_MODQ_EN
  // Adding Q to the sign-extended value wraps modulo 2^COEF_W to Q+value.
  assign coef_val = nibble[3] ? (COEF_W'(Q) + nib_sext) : nib_sext;
`else
  assign coef_val = nib_sext;
`endif

  // Only EMIT presents a coefficient; every other state drives zero.
  assign out_data = out_valid ? coef_val : '0;
  assign out_idx  = coef_cnt;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned; without it this process would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start)  state_nxt = S_LOAD;
      S_LOAD: if (in_hs)  state_nxt = S_WAIT;
      S_WAIT:             state_nxt = S_EMIT;
      S_EMIT: begin
        if (out_hs && last_nib) begin
          state_nxt = last_coef ? S_DONE : S_LOAD;
        end
      end
      S_DONE:             state_nxt = S_IDLE;
      default:            state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: nib_buf is a plain 32-bit register, not a memory array, so it is
  // reset with everything else; out_data then reads a defined value after
  // reset without relying on the EMIT gating alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      nib_buf  <= '0;
      nib_cnt  <= '0;
      coef_cnt <= '0;
    end else begin
      state <= state_nxt;

      if (state == S_WAIT) begin
        nib_buf <= cal_dout;
      end

      if (out_hs) begin
        // nib_cnt wraps 7->0 naturally; coef_cnt wraps at NCOEF-1.
        nib_cnt  <= nib_cnt + 3'd1;
        coef_cnt <= last_coef ? '0 : coef_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_cbd2_sampler_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cbd2_sampler_ctrl
//
// Self-checking bench for cbd2_sampler_ctrl. The bench plays the cbd2 unit
// (eta=2 arithmetic on cal_din, result registered one cycle later), the PRF
// word source and the coefficient sink. Expected coefficients come from a
// table of hand-computed vectors and from a reference model that evaluates
// a0+a1-(b0+b1) per nibble with integer arithmetic.
// Honours CBD2_CTRL_MODQ_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_cbd2_sampler_ctrl;

  localparam int NCOEF  = 256;
  localparam int Q      = 3329;
  localparam int COEF_W = 12;
  localparam int NWORDS = NCOEF / 8;
  localparam int BUDGET = 4000;

`ifdef CBD2_CTRL_MODQ_EN
  localparam logic [11:0] NEG1 = 12'd3328;
  localparam logic [11:0] NEG2 = 12'd3327;
`else
  localparam logic [11:0] NEG1 = 12'hFFF;
  localparam logic [11:0] NEG2 = 12'hFFE;
`endif

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              busy;
  logic              done;
  logic [31:0]       in_data;
  logic              in_valid;
  logic              in_ready;
  logic              cal_set;
  logic [31:0]       cal_din;
  logic [31:0]       cal_dout;
  logic [COEF_W-1:0] out_data;
  logic [7:0]        out_idx;
  logic              out_valid;
  logic              out_ready;

  cbd2_sampler_ctrl #(.NCOEF(NCOEF), .Q(Q), .COEF_W(COEF_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cal_set   (cal_set),
    .cal_din   (cal_din),
    .cal_dout  (cal_dout),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference arithmetic
  // ---------------------------------------------------------------------------
  function automatic int cbd2_val(logic [31:0] w, int j);
    int a, b;
    a = int'(w[4*j])   + int'(w[4*j+1]);
    b = int'(w[4*j+2]) + int'(w[4*j+3]);
    return a - b;
  endfunction

  function automatic logic [31:0] cbd2_unit(logic [31:0] w);
    logic [31:0] r;
    int v;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      v = cbd2_val(w, j);
      r[4*j +: 4] = 4'(v);
    end
    return r;
  endfunction

  function automatic logic [11:0] ref_coef(logic [31:0] w, int j);
    int v;
    v = cbd2_val(w, j);
`ifdef CBD2_CTRL_MODQ_EN
    return (v < 0) ? 12'(Q + v) : 12'(v);
`else
    return 12'(v);
`endif
  endfunction

  // The cbd2 unit: result appears the cycle after cal_set; garbage otherwise,
  // so a capture on the wrong cycle shows up as wrong coefficients.
  always @(posedge clk) begin
    if (cal_set) cal_dout <= cbd2_unit(cal_din);
    else         cal_dout <= $urandom;
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0]      word;
    logic [7:0][11:0] exp;
  } vec_t;

  function automatic vec_t mk(logic [31:0] w,
                              logic [11:0] e0, logic [11:0] e1,
                              logic [11:0] e2, logic [11:0] e3,
                              logic [11:0] e4, logic [11:0] e5,
                              logic [11:0] e6, logic [11:0] e7);
    vec_t v;
    v.word   = w;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    v.exp[4] = e4; v.exp[5] = e5; v.exp[6] = e6; v.exp[7] = e7;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Polynomial run: source, sink, scoreboard capture
  // ---------------------------------------------------------------------------
  logic [31:0] words [NWORDS];
  bit          rdy_rand, in_rand, stall37;
  int          gap_word, inj_idx, rst_idx;

  logic [11:0] rx_data [$];
  int          rx_idx  [$];
  int          n_calset, n_done, cyc_done, last_hs_cyc;
  bit          aborted;

  task automatic set_knobs(bit rr, bit ir, bit s37, int gw, int ii, int ri);
    rdy_rand = rr; in_rand = ir; stall37 = s37;
    gap_word = gw; inj_idx = ii; rst_idx = ri;
  endtask

  task automatic run_poly();
    int          wi, gap_left, stall_left, bad_tail;
    bit          gap_done, stall_done, inj_done, saw_done, prev_hold, finished;
    logic [11:0] hd;
    logic [7:0]  hi;
    wi = 0; gap_left = 0; stall_left = 0; bad_tail = 0;
    gap_done = 0; stall_done = 0; inj_done = 0; saw_done = 0;
    prev_hold = 0; finished = 0;
    hd = '0; hi = '0;
    rx_data.delete(); rx_idx.delete();
    n_calset = 0; n_done = 0; cyc_done = -1; last_hs_cyc = -1; aborted = 0;

    @(negedge clk);
    check("idle_before_start", busy, 1'b0);
    start = 1'b1;
    @(negedge clk);

    for (int cyc = 0; cyc < BUDGET && !finished; cyc++) begin
      // ---- drive ----
      start = 1'b0;
      if (rst_idx >= 0 && out_valid && int'(out_idx) == rst_idx) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy",      busy,      1'b0);
        check("rst_done",      done,      1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data",  out_data,  '0);
        check("rst_out_idx",   out_idx,   '0);
        check("rst_in_ready",  in_ready,  1'b0);
        check("rst_cal_set",   cal_set,   1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1;
        return;
      end
      if (!gap_done && gap_word == wi && in_ready) begin
        gap_left = 7;
        gap_done = 1;
      end
      in_valid = (wi < NWORDS) && (gap_left == 0) &&
                 (!in_rand || $urandom_range(0, 3) != 0);
      in_data  = (wi < NWORDS) ? words[wi] : $urandom;
      if (stall37 && !stall_done && out_valid && out_idx == 8'd37) begin
        stall_left = 5;
        stall_done = 1;
      end
      out_ready = (stall_left > 0) ? 1'b0 :
                  (rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
      if (!inj_done && inj_idx >= 0 && out_valid && int'(out_idx) == inj_idx) begin
        start    = 1'b1;
        inj_done = 1;
      end
      #1;

      // ---- observe ----
      check("cal_set_eq_hs", cal_set, in_valid & in_ready);
      if (cal_set) check("cal_din", cal_din, in_data);
      if (gap_left > 0) begin
        check("gap_holds_load", in_ready, 1'b1);
        gap_left--;
      end
      if (prev_hold) begin
        check("hold_data",  out_data,  hd);
        check("hold_idx",   out_idx,   hi);
        check("hold_valid", out_valid, 1'b1);
      end
      if (stall_left > 0) begin
        check("stall_in_ready", in_ready, 1'b0);
        stall_left--;
      end
      if (in_valid && in_ready) begin
        n_calset++;
        wi++;
      end
      if (out_valid && out_ready) begin
        rx_data.push_back(out_data);
        rx_idx.push_back(int'(out_idx));
        if (rx_data.size() == NCOEF) last_hs_cyc = cyc;
      end
      prev_hold = out_valid && !out_ready;
      hd = out_data;
      hi = out_idx;
      if (saw_done) begin
        check("busy_after_done", busy, 1'b0);
        finished = 1;
      end else if (done) begin
        n_done++;
        saw_done = 1;
        cyc_done = cyc;
        check("done_timing",    cyc,       last_hs_cyc + 1);
        check("done_busy",      busy,      1'b1);
        check("done_out_valid", out_valid, 1'b0);
        check("done_in_ready",  in_ready,  1'b0);
        check("done_out_data",  out_data,  '0);
        check("done_out_idx",   out_idx,   '0);
      end
      if (!finished) @(negedge clk);
    end
    check("poly_completed", finished, 1'b1);

    // Idle tail: an ignored start must not have restarted the sequence.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (busy || done || in_ready || cal_set) bad_tail++;
      if (done) n_done++;
    end
    in_valid = 1'b0;
    check("idle_tail_quiet", bad_tail, 0);
  endtask

  task automatic compare_model(int n);
    check("rx_count", rx_data.size(), n);
    for (int i = 0; i < rx_data.size() && i < n; i++) begin
      check("model_idx",  rx_idx[i],  i);
      check("model_data", rx_data[i], ref_coef(words[i/8], i%8));
    end
  endtask

  task automatic random_words();
    for (int k = 0; k < NWORDS; k++) words[k] = $urandom;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  vec_t vtab [8];

  initial begin
    logic [11:0] e;
    vtab[0] = mk(32'h0000C413, 12'd2, 12'd1, NEG1, NEG2, 12'd0, 12'd0, 12'd0, 12'd0);
    vtab[1] = mk(32'hFFFFFFFF, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0);
    vtab[2] = mk(32'h00000000, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0);
    vtab[3] = mk(32'h33333333, 12'd2, 12'd2, 12'd2, 12'd2, 12'd2, 12'd2, 12'd2, 12'd2);
    vtab[4] = mk(32'hCCCCCCCC, NEG2, NEG2, NEG2, NEG2, NEG2, NEG2, NEG2, NEG2);
    vtab[5] = mk(32'h12345678, NEG1, 12'd1, 12'd0, 12'd0, NEG1, 12'd2, 12'd1, 12'd1);
    vtab[6] = mk(32'h55555555, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0);
    vtab[7] = mk(32'h44444444, NEG1, NEG1, NEG1, NEG1, NEG1, NEG1, NEG1, NEG1);

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy",      busy,      1'b0);
    check("reset_done",      done,      1'b0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data",  out_data,  '0);
    check("reset_out_idx",   out_idx,   '0);
    check("reset_in_ready",  in_ready,  1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // in_valid while IDLE is not consumed.
    in_valid = 1'b1; in_data = 32'hDEADBEEF;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("idle_in_ready", in_ready, 1'b0);
      check("idle_cal_set",  cal_set,  1'b0);
    end
    in_valid = 1'b0;

    // Table-driven polynomial at full throughput.
    for (int k = 0; k < NWORDS; k++) words[k] = (k < 8) ? vtab[k].word : 32'h0;
    set_knobs(0, 0, 0, -1, -1, -1);
    run_poly();
    check("tab_latency",  cyc_done, 320);
    check("tab_cal_sets", n_calset, NWORDS);
    check("tab_dones",    n_done,   1);
    check("tab_count",    rx_data.size(), NCOEF);
    for (int i = 0; i < rx_data.size(); i++) begin
      e = (i / 8 < 8) ? vtab[i/8].exp[i%8] : 12'd0;
      check("tab_idx",  rx_idx[i],  i);
      check("tab_data", rx_data[i], e);
    end

    // All 0xFFFFFFFF: every coefficient is zero, 32 cal_set pulses.
    for (int k = 0; k < NWORDS; k++) words[k] = 32'hFFFFFFFF;
    run_poly();
    check("ones_cal_sets", n_calset, NWORDS);
    compare_model(NCOEF);

    // Random words with backpressure, input gaps, stall at 37, 7-cycle gap.
    random_words();
    set_knobs(1, 1, 1, 5, -1, -1);
    run_poly();
    check("rand_latency_min", cyc_done >= 320, 1'b1);
    check("rand_cal_sets", n_calset, NWORDS);
    check("rand_dones",    n_done,   1);
    compare_model(NCOEF);

    // start while busy at idx 100 is ignored.
    random_words();
    set_knobs(0, 0, 0, -1, 100, -1);
    run_poly();
    check("inj_dones",    n_done,   1);
    check("inj_cal_sets", n_calset, NWORDS);
    compare_model(NCOEF);

    // Reset at idx 150 aborts; partial output matches the model so far.
    random_words();
    set_knobs(0, 0, 0, -1, -1, 150);
    run_poly();
    check("rst_aborted", aborted, 1'b1);
    compare_model(150);

    // Clean polynomial after the abort.
    random_words();
    set_knobs(1, 0, 0, -1, -1, -1);
    run_poly();
    check("post_rst_dones", n_done, 1);
    compare_model(NCOEF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
